// File: rtl/fir_stream_ctrl.sv
// Stream controller that feeds an external pipelined FIR filter and buffers its results in a FIFO.
// Define FIR_STREAM_CTRL_STATS_EN to add the stat_samples / stat_stalls counter outputs.
module fir_stream_ctrl #(
  parameter int NTAPS  = 63,
  parameter int PIPE   = 1,
  parameter int ODEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        flush,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  output logic        filt_ena,
  output logic [15:0] filt_x,
  input  logic [31:0] filt_y,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_settled,
  output logic        busy
`ifdef FIR_STREAM_CTRL_STATS_EN
  ,
  output logic [31:0] stat_samples,
  output logic [31:0] stat_stalls
`endif
);

  localparam int PW     = $clog2(ODEPTH);
  localparam int CW     = PW + 2;
  localparam int CAPMAX = PIPE + NTAPS - 1;
  localparam int KW     = $clog2(CAPMAX + 1);
  localparam int FW     = $clog2(PIPE + 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;

  state_t          state, state_nxt;
  logic            cap_vld;
  logic [1:0]      inflight;
  logic            credit, hs, flush_issue, push, pop, push_settled;
  logic [PW:0]     fifo_count;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [32:0]     mem [ODEPTH];
  logic [KW-1:0]   cap_cnt;
  logic [FW-1:0]   flush_cnt;

  // A pulse is in flight from the cycle filt_ena is high until its capture cycle.
  assign inflight     = {1'b0, filt_ena} + {1'b0, cap_vld};
  assign credit       = (CW'(fifo_count) + CW'(inflight)) < CW'(ODEPTH);
  assign s_ready      = (state == RUN) && credit;
  assign hs           = s_valid && s_ready;
  assign flush_issue  = (state == FLUSH) && credit;

  // Capture n of a run carries the result of sample n-PIPE; earlier captures are stale.
  assign push         = cap_vld && (cap_cnt >= KW'(PIPE));
  assign push_settled = (cap_cnt >= KW'(CAPMAX));

  assign m_valid   = (fifo_count != '0);
  assign pop       = m_valid && m_ready;
  assign m_data    = m_valid ? mem[rd_ptr][31:0] : 32'd0;
  assign m_settled = m_valid && mem[rd_ptr][32];
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (flush) state_nxt = FLUSH;
      FLUSH:   if (flush_issue && (flush_cnt == FW'(PIPE - 1))) state_nxt = DRAIN;
      DRAIN:   if (inflight == 2'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      filt_ena  <= 1'b0;
      filt_x    <= 16'd0;
      cap_vld   <= 1'b0;
      cap_cnt   <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_nxt;
      filt_ena <= hs || flush_issue;
      cap_vld  <= filt_ena;
      if (hs)
        filt_x <= s_data;
      else if (flush_issue)
        filt_x <= 16'd0;
      if ((state == IDLE) && start)
        cap_cnt <= '0;
      else if (cap_vld && (cap_cnt != KW'(CAPMAX)))
        cap_cnt <= cap_cnt + 1'b1;
      if (state != FLUSH)
        flush_cnt <= '0;
      else if (flush_issue)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset: m_data/m_settled are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {push_settled, filt_y};
  end

`ifdef FIR_STREAM_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_samples <= 32'd0;
      stat_stalls  <= 32'd0;
    end else begin
      if (hs) stat_samples <= stat_samples + 32'd1;
      if ((state == RUN) && s_valid && !s_ready) stat_stalls <= stat_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Scoreboard bench for fir_stream_ctrl: random samples, a behavioural pipelined filter, in-order result checking.
module tb_fir_stream_ctrl;

  localparam int NTAPS  = 63;
  localparam int PIPE   = 1;
  localparam int ODEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = 16'd0;
  logic        filt_ena;
  logic [15:0] filt_x;
  logic [31:0] filt_y = 32'd0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic        m_settled;
  logic        busy;
`ifdef FIR_STREAM_CTRL_STATS_EN
  logic [31:0] stat_samples;
  logic [31:0] stat_stalls;
`endif

  int          n_vec = 0;
  int          n_fail = 0;
  int          run_k = 0;
  int          n_out = 0;
  int          tot_acc = 0;
  int          tot_stall = 0;
  int          ready_mode = 0;
  logic [32:0] exp_q[$];
  logic [31:0] filt_pend = 32'd0;

  fir_stream_ctrl #(.NTAPS(NTAPS), .PIPE(PIPE), .ODEPTH(ODEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .filt_ena(filt_ena), .filt_x(filt_x), .filt_y(filt_y),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_settled(m_settled),
    .busy(busy)
`ifdef FIR_STREAM_CTRL_STATS_EN
    , .stat_samples(stat_samples), .stat_stalls(stat_stalls)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] filt_fn(input logic [15:0] x);
    int v;
    v = int'($signed(x));
    return 32'(v * 37 - 5);
  endfunction

  // External filter: the result of each enable pulse shows up on filt_y after the next pulse.
  always @(posedge clk) begin
    if (filt_ena) begin
      filt_y    <= filt_pend;
      filt_pend <= filt_fn(filt_x);
    end
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       m_ready = 1'b0;
      1:       m_ready = 1'b1;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every result leaving the DUT must match the oldest expected entry.
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst_n && m_valid && m_ready) begin
      checkOutput("result_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput("m_data", m_data, e[31:0]);
        checkOutput("m_settled", 32'(m_settled), 32'(e[32]));
      end
      n_out++;
    end
  end

  task automatic applyStimulus(input logic [15:0] d, output int waitc);
    waitc = 0;
    s_valid = 1'b1;
    s_data  = d;
    @(negedge clk);
    while (!s_ready && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    tot_stall += waitc;
    if (!s_ready) begin
      checkOutput("handshake_timeout", 32'(s_ready), 32'd1);
    end else begin
      exp_q.push_back({(run_k >= NTAPS - 1), filt_fn(d)});
      run_k++;
      tot_acc++;
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic startRun();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    run_k = 0;
  endtask

  task automatic pulseFlush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic setReady(input int mode);
    @(negedge clk);
    ready_mode = mode;
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle();
    int c;
    c = 0;
    while ((busy || m_valid) && c < 400) begin
      @(negedge clk);
      c++;
    end
    checkOutput("drain_idle_busy", 32'(busy), 32'd0);
    checkOutput("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int w, imm, n0;

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rst_s_ready", 32'(s_ready), 32'd0);
    checkOutput("rst_filt_ena", 32'(filt_ena), 32'd0);
    checkOutput("rst_filt_x", 32'(filt_x), 32'd0);
    checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
    checkOutput("rst_m_data", m_data, 32'd0);
    checkOutput("rst_m_settled", 32'(m_settled), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    setReady(1);

    // Flush alone in IDLE is ignored; start+flush together starts a run; flush in RUN ends it
    pulseFlush();
    @(negedge clk);
    checkOutput("idle_flush_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    run_k = 0;
    @(negedge clk);
    checkOutput("startflush_busy", 32'(busy), 32'd1);
    checkOutput("startflush_s_ready", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
    pulseFlush();
    @(negedge clk);
    checkOutput("flush_s_ready", 32'(s_ready), 32'd0);
    checkOutput("flush_busy", 32'(busy), 32'd1);
    waitIdle();

    // Single sample: pulse one cycle after handshake, stale first result dropped
    startRun();
    n0 = n_out;
    applyStimulus(16'h0100, w);
    @(negedge clk);
    checkOutput("single_filt_ena", 32'(filt_ena), 32'd1);
    checkOutput("single_filt_x", 32'(filt_x), 32'h0100);
    @(negedge clk);
    checkOutput("single_filt_ena_off", 32'(filt_ena), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("single_m_valid", 32'(m_valid), 32'd0);
    end
    pulseFlush();
    waitIdle();
    checkOutput("single_out_count", 32'(n_out - n0), 32'd1);

    // Samples 1,2,3 then flush: exactly three results, a zero pulse issued by the flush
    startRun();
    n0 = n_out;
    for (int i = 1; i <= 3; i++) applyStimulus(16'(i), w);
    pulseFlush();
    @(negedge clk);
    @(negedge clk);
    checkOutput("flush_pulse_ena", 32'(filt_ena), 32'd1);
    checkOutput("flush_pulse_x", 32'(filt_x), 32'd0);
    waitIdle();
    checkOutput("three_out_count", 32'(n_out - n0), 32'd3);

    // Backpressure: ODEPTH results plus the PIPE stale captures fit before stalling
    setReady(0);
    startRun();
    n0 = n_out;
    imm = 0;
    for (int i = 0; i < ODEPTH + PIPE; i++) begin
      applyStimulus(16'($urandom), w);
      if (w == 0) imm++;
    end
    checkOutput("bp_accepted", 32'(imm), 32'(ODEPTH + PIPE));
    s_valid = 1'b1;
    s_data  = 16'($urandom);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("bp_s_ready", 32'(s_ready), 32'd0);
    end
    tot_stall += 8;
    checkOutput("bp_m_valid", 32'(m_valid), 32'd1);
    ready_mode = 1;
    applyStimulus(s_data, w);
    for (int i = 0; i < 3; i++) applyStimulus(16'($urandom), w);
    pulseFlush();
    waitIdle();
    checkOutput("bp_out_count", 32'(n_out - n0), 32'(ODEPTH + PIPE + 4));

    // Settled flag across a long run with random gaps and random m_ready; start mid-run is ignored
    setReady(2);
    startRun();
    n0 = n_out;
    for (int k = 0; k < 70; k++) begin
      if (k == 30) begin
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      applyStimulus(16'($urandom), w);
    end
    pulseFlush();
    setReady(1);
    waitIdle();
    checkOutput("long_out_count", 32'(n_out - n0), 32'd70);
`ifdef FIR_STREAM_CTRL_STATS_EN
    checkOutput("stat_samples", stat_samples, 32'(tot_acc));
    checkOutput("stat_stalls", stat_stalls, 32'(tot_stall));
`endif

    // Reset during FLUSH with two results buffered
    setReady(0);
    startRun();
    for (int i = 0; i < 3; i++) applyStimulus(16'($urandom), w);
    repeat (4) @(negedge clk);
    checkOutput("pre_rst_m_valid", 32'(m_valid), 32'd1);
    @(posedge clk);
    #1;
    pulseFlush();
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_m_valid", 32'(m_valid), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_s_ready", 32'(s_ready), 32'd0);
    exp_q.delete();
    tot_acc = 0;
    tot_stall = 0;
    @(negedge clk);
    checkOutput("midrst_s_ready_next", 32'(s_ready), 32'd0);
    checkOutput("midrst_filt_ena", 32'(filt_ena), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Recovery run after the abort
    setReady(1);
    startRun();
    n0 = n_out;
    for (int i = 0; i < 2; i++) applyStimulus(16'($urandom), w);
    pulseFlush();
    waitIdle();
    checkOutput("recover_out_count", 32'(n_out - n0), 32'd2);
`ifdef FIR_STREAM_CTRL_STATS_EN
    checkOutput("stat_samples_after_rst", stat_samples, 32'(tot_acc));
    checkOutput("stat_stalls_after_rst", stat_stalls, 32'(tot_stall));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
